mem_parity_ctl: RTL and testbench

//  Bus-side controller for the 128KW byte-writeable, parity-protected memory array (18-bit words, 2-cycle read latency).

---
 rtl/mem_parity_pkg.sv | 27 ++
 rtl/mem_par_lane.sv | 22 ++
 rtl/mem_parity_ctl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_parity_ctl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_parity_pkg.sv
// Shared types and constants for the parity-protected memory controller.
//   state_e  : controller FSM states
//   oddpar() : odd-parity bit for one byte (makes the 9-bit lane have an odd 1-count)
//   widths   : word/byte address widths, lane packing of the 18-bit array word
package mem_parity_pkg;

    localparam int unsigned WORD_AW = 17;   // array word address width
    localparam int unsigned BYTE_AW = 18;   // bus byte address width
    localparam int unsigned DATA_W  = 16;   // bus data width
    localparam int unsigned MEM_W   = 18;   // array word width
    localparam int unsigned LANE_W  = 9;    // {par, byte}
    localparam int unsigned LO_LSB  = 0;    // low lane position in the array word
    localparam int unsigned HI_LSB  = 9;    // high lane position in the array word

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        W1,
        W2,
        RESP
    } state_e;

    function automatic logic oddpar(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/mem_par_lane.sv
// One byte lane of the array word.
//   wbyte_i  : byte to store
//   badpar_i : store even (wrong) parity instead of odd
//   wlane_o  : {parity, byte} to write into the array
//   rlane_i  : {parity, byte} read back from the array
//   bad_o    : read-back lane fails the odd-parity check
module mem_par_lane
    import mem_parity_pkg::*;
(
    input  logic [7:0]        wbyte_i,
    input  logic              badpar_i,
    output logic [LANE_W-1:0] wlane_o,
    input  logic [LANE_W-1:0] rlane_i,
    output logic              bad_o
);

    always_comb begin
        wlane_o = {oddpar(wbyte_i) ^ badpar_i, wbyte_i};
        bad_o   = rlane_i[8] ^ oddpar(rlane_i[7:0]);
    end

endmodule

// File: rtl/mem_parity_ctl.sv
// Bus-side controller for the byte-writeable, parity-protected memory array
// (18-bit words, 2-cycle read latency).
//   CLOCK, RESET_N      : system clock, async active-low reset
//   req_*               : request from the bus slave (accepted when req_ready)
//   rsp_*               : one-cycle response pulse with read data / NXM / parity error
//   diag_badpar         : write even parity on the enabled lanes (diagnostic)
//   perr_clr/flag/addr  : sticky parity-error flag and first-error byte address
//   mem_*               : registered array interface, mem_douta read back
module mem_parity_ctl
    import mem_parity_pkg::*;
#(
    parameter int unsigned MEMWORDS = 131072
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_byte,
    input  logic [BYTE_AW-1:0] req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_nxm,
    output logic               rsp_perr,
    input  logic               diag_badpar,
    input  logic               perr_clr,
    output logic               perr_flag,
    output logic [BYTE_AW-1:0] perr_addr,
    output logic               mem_ena,
    output logic [1:0]         mem_wea,
    output logic [WORD_AW-1:0] mem_addra,
    output logic [MEM_W-1:0]   mem_dina,
    input  logic [MEM_W-1:0]   mem_douta
);

    localparam logic [WORD_AW:0] MEM_LIMIT = (WORD_AW + 1)'(MEMWORDS);

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 write_q, write_d;
    logic [WORD_AW-1:0]   word_q, word_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_nxm_q, rsp_nxm_d;
    logic                 rsp_perr_q, rsp_perr_d;
    logic                 perr_flag_q, perr_flag_d;
    logic [BYTE_AW-1:0]   perr_addr_q, perr_addr_d;
    logic                 mem_ena_q, mem_ena_d;
    logic [1:0]           mem_wea_q, mem_wea_d;
    logic [WORD_AW-1:0]   mem_addra_q, mem_addra_d;
    logic [MEM_W-1:0]     mem_dina_q, mem_dina_d;

    logic [WORD_AW-1:0]   req_word;
    logic                 accept;
    logic                 nxm;
    logic [7:0]           lo_wbyte;
    logic [1:0]           wea_req;
    logic [LANE_W-1:0]    lo_wlane, hi_wlane;
    logic                 lo_bad, hi_bad;
    logic                 rd_err;

    // Odd-lane byte writes carry their data in [15:8]; mirror it into the
    // low lane too so both lanes of dina hold the same byte.
    always_comb begin
        req_word = req_addr[BYTE_AW-1:1];
        accept   = req_valid & ready_q;
        nxm      = ({1'b0, req_word} >= MEM_LIMIT);
        lo_wbyte = (req_byte & req_addr[0]) ? req_wdata[15:8] : req_wdata[7:0];
        if (!req_byte) begin
            wea_req = 2'b11;
        end else if (req_addr[0]) begin
            wea_req = 2'b10;
        end else begin
            wea_req = 2'b01;
        end
    end

    mem_par_lane u_lane_lo (
        .wbyte_i  (lo_wbyte),
        .badpar_i (diag_badpar),
        .wlane_o  (lo_wlane),
        .rlane_i  (mem_douta[LO_LSB +: LANE_W]),
        .bad_o    (lo_bad)
    );

    mem_par_lane u_lane_hi (
        .wbyte_i  (req_wdata[15:8]),
        .badpar_i (diag_badpar),
        .wlane_o  (hi_wlane),
        .rlane_i  (mem_douta[HI_LSB +: LANE_W]),
        .bad_o    (hi_bad)
    );

    assign rd_err = lo_bad | hi_bad;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        word_d      = word_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nxm_d   = rsp_nxm_q;
        rsp_perr_d  = rsp_perr_q;
        perr_flag_d = perr_flag_q;
        perr_addr_d = perr_addr_q;
        mem_ena_d   = 1'b1;
        mem_wea_d   = '0;
        mem_addra_d = mem_addra_q;
        mem_dina_d  = mem_dina_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = req_word;
                    write_d = req_write;
                    if (nxm) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_nxm_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_addra_d = req_word;
                        if (req_write) begin
                            mem_wea_d  = wea_req;
                            mem_dina_d = {hi_wlane, lo_wlane};
                        end
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = W1;
                end
            end
            W1: state_d = W2;
            W2: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {mem_douta[HI_LSB +: 8], mem_douta[LO_LSB +: 8]};
                rsp_perr_d  = rd_err;
            end
            RESP: begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_nxm_d   = 1'b0;
                rsp_perr_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A read error beats a simultaneous clear and reloads the address.
        if ((state_q == W2) && rd_err) begin
            if (!perr_flag_q || perr_clr) begin
                perr_addr_d = {word_q, 1'b0};
            end
            perr_flag_d = 1'b1;
        end else if (perr_clr) begin
            perr_flag_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            word_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_nxm_q   <= 1'b0;
            rsp_perr_q  <= 1'b0;
            perr_flag_q <= 1'b0;
            perr_addr_q <= '0;
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= '0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            write_q     <= write_d;
            word_q      <= word_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nxm_q   <= rsp_nxm_d;
            rsp_perr_q  <= rsp_perr_d;
            perr_flag_q <= perr_flag_d;
            perr_addr_q <= perr_addr_d;
            mem_ena_q   <= mem_ena_d;
            mem_wea_q   <= mem_wea_d;
            mem_addra_q <= mem_addra_d;
            mem_dina_q  <= mem_dina_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nxm   = rsp_nxm_q;
    assign rsp_perr  = rsp_perr_q;
    assign perr_flag = perr_flag_q;
    assign perr_addr = perr_addr_q;
    assign mem_ena   = mem_ena_q;
    assign mem_wea   = mem_wea_q;
    assign mem_addra = mem_addra_q;
    assign mem_dina  = mem_dina_q;

endmodule

// File: tb/tb_mem_parity_ctl.sv
// Testbench for mem_parity_ctl: directed scenarios plus randomized traffic,
// checked against a word/lane-level reference model of the memory contents
// and the parity-error latch. A small 2-cycle-latency array model sits on
// the memory port.
module tb_mem_parity_ctl;

    localparam int unsigned NW = 1024;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_nxm, rsp_perr;
    logic [15:0] rsp_rdata;
    logic        diag_badpar, perr_clr, perr_flag;
    logic [17:0] perr_addr;
    logic        mem_ena;
    logic [1:0]  mem_wea;
    logic [16:0] mem_addra;
    logic [17:0] mem_dina, mem_douta;

    always #5 CLOCK = ~CLOCK;

    mem_parity_ctl #(.MEMWORDS(NW)) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_byte    (req_byte),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_nxm     (rsp_nxm),
        .rsp_perr    (rsp_perr),
        .diag_badpar (diag_badpar),
        .perr_clr    (perr_clr),
        .perr_flag   (perr_flag),
        .perr_addr   (perr_addr),
        .mem_ena     (mem_ena),
        .mem_wea     (mem_wea),
        .mem_addra   (mem_addra),
        .mem_dina    (mem_dina),
        .mem_douta   (mem_douta)
    );

    // Array model: lane writes, 2-cycle registered read. Starts with good-parity zeros.
    logic [17:0] arr [NW];
    logic [17:0] rd_s1 = '0;
    logic [17:0] douta_r = '0;
    bit          arr_init = 1'b0;

    always @(posedge CLOCK) begin
        if (!arr_init) begin
            for (int i = 0; i < int'(NW); i++) arr[i] <= 18'h20100;
            arr_init <= 1'b1;
        end else if (mem_ena) begin
            if (32'(mem_addra) < NW) begin
                if (mem_wea[0]) arr[mem_addra[9:0]][8:0]  <= mem_dina[8:0];
                if (mem_wea[1]) arr[mem_addra[9:0]][17:9] <= mem_dina[17:9];
                rd_s1 <= arr[mem_addra[9:0]];
            end else begin
                rd_s1 <= '0;
            end
            douta_r <= rd_s1;
        end
    end
    assign mem_douta = douta_r;

    // Reference model
    logic [15:0] ref_data [NW];
    bit          ref_bhi  [NW];
    bit          ref_blo  [NW];
    bit          ref_flag;
    logic [17:0] ref_paddr;

    int n_total = 0;
    int n_bad   = 0;

    function automatic logic par_of(input logic [7:0] b, input bit bad);
        return ((($countones(b) % 2) == 0) ? 1'b1 : 1'b0) ^ bad;
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit wr, input bit bt, input logic [17:0] a,
                       input logic [15:0] d, input bit bp, input bit clr_w2);
        logic [16:0] w;
        logic [9:0]  ix;
        bit          nxm;
        int          exp_lat;
        logic [7:0]  hb, lb;
        logic [1:0]  ewea;
        logic [17:0] edina;
        logic [15:0] erd;
        bit          eperr;
        int          edges;
        bit          got;

        w       = a[17:1];
        ix      = w[9:0];
        nxm     = (32'(w) >= NW);
        exp_lat = nxm ? 1 : (wr ? 2 : 4);
        hb      = d[15:8];
        lb      = (bt && a[0]) ? d[15:8] : d[7:0];
        ewea    = !bt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        edina   = {par_of(hb, bp), hb, par_of(lb, bp), lb};
        erd     = '0;
        eperr   = 1'b0;
        if (!nxm) begin
            if (wr) begin
                if (ewea[1]) begin ref_data[ix][15:8] = hb; ref_bhi[ix] = bp; end
                if (ewea[0]) begin ref_data[ix][7:0]  = lb; ref_blo[ix] = bp; end
            end else begin
                erd   = ref_data[ix];
                eperr = ref_bhi[ix] | ref_blo[ix];
                if (eperr) begin
                    if (!ref_flag || clr_w2) ref_paddr = {w, 1'b0};
                    ref_flag = 1'b1;
                end else if (clr_w2) begin
                    ref_flag = 1'b0;
                end
            end
        end

        edges = 0;
        @(negedge CLOCK);
        while (!req_ready && edges < 20) begin
            @(negedge CLOCK);
            edges++;
        end
        check("ready_before_req", 18'(req_ready), 18'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_byte    = bt;
        req_addr    = a;
        req_wdata   = d;
        diag_badpar = bp;
        @(posedge CLOCK);
        #1;
        req_valid   = 1'b0;
        req_wdata   = 16'($urandom);
        req_addr    = 18'($urandom);
        req_write   = 1'($urandom);
        req_byte    = 1'($urandom);
        diag_badpar = 1'($urandom);

        edges = 1;
        got   = 1'b0;
        while (!got && edges <= 12) begin
            if (edges == 1 && !nxm) begin
                check("issue_addra", 18'(mem_addra), 18'(w));
                if (wr) begin
                    check("issue_wea", 18'(mem_wea), 18'(ewea));
                    check("issue_dina", mem_dina, edina);
                end else begin
                    check("issue_wea_rd", 18'(mem_wea), 18'd0);
                end
            end else begin
                check("wea_quiet", 18'(mem_wea), 18'd0);
            end
            if (clr_w2 && edges == 3) perr_clr = 1'b1;
            if (edges == 4) perr_clr = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                @(posedge CLOCK);
                #1;
                edges++;
            end
        end
        perr_clr = 1'b0;

        check("rsp_seen", 18'(got), 18'd1);
        check("latency", 18'(edges), 18'(exp_lat));
        check("rsp_rdata", 18'(rsp_rdata), 18'(erd));
        check("rsp_nxm", 18'(rsp_nxm), 18'(nxm));
        check("rsp_perr", 18'(rsp_perr), 18'(eperr));
        check("perr_flag", 18'(perr_flag), 18'(ref_flag));
        check("perr_addr", perr_addr, ref_paddr);
        @(posedge CLOCK);
        #1;
        check("rsp_pulse_end", 18'(rsp_valid), 18'd0);
        check("rdata_cleared", 18'(rsp_rdata), 18'd0);
    endtask

    task automatic clr_alone();
        @(negedge CLOCK);
        perr_clr = 1'b1;
        @(negedge CLOCK);
        perr_clr = 1'b0;
        ref_flag = 1'b0;
        check("clr_flag", 18'(perr_flag), 18'd0);
        check("clr_addr_hold", perr_addr, ref_paddr);
    endtask

    initial begin
        RESET_N     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_byte    = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        diag_badpar = 1'b0;
        perr_clr    = 1'b0;
        ref_flag    = 1'b0;
        ref_paddr   = '0;
        for (int i = 0; i < int'(NW); i++) begin
            ref_data[i] = '0;
            ref_bhi[i]  = 1'b0;
            ref_blo[i]  = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge CLOCK);
        check("rst_ready", 18'(req_ready), 18'd0);
        check("rst_rsp_valid", 18'(rsp_valid), 18'd0);
        check("rst_mem_ena", 18'(mem_ena), 18'd0);
        check("rst_wea", 18'(mem_wea), 18'd0);
        check("rst_dina", mem_dina, 18'd0);
        check("rst_perr_flag", 18'(perr_flag), 18'd0);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        check("post_rst_ready", 18'(req_ready), 18'd1);
        check("post_rst_ena", 18'(mem_ena), 18'd1);

        // T1 word write / read
        txn(1'b1, 1'b0, 18'o000100, 16'h1234, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 18'o000100, 16'h0000, 1'b0, 1'b0);
        // T2 odd byte write, read back merged word
        txn(1'b1, 1'b1, 18'o000101, 16'hAB00, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 18'o000100, 16'h0000, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 18'o000100, 16'hEECD, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 18'o000101, 16'h0000, 1'b0, 1'b0);
        // T3 bad parity writes, first error latched, second keeps address
        txn(1'b1, 1'b0, 18'o000200, 16'h00FF, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 18'o000300, 16'h5A5A, 1'b1, 1'b0);
        txn(1'b0, 1'b0, 18'o000200, 16'h0000, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 18'o000300, 16'h0000, 1'b0, 1'b0);
        // T4 clear coinciding with an error, then clear alone
        txn(1'b0, 1'b0, 18'o000300, 16'h0000, 1'b0, 1'b1);
        clr_alone();
        // T5 NXM boundary
        txn(1'b0, 1'b0, 18'o004000, 16'h0000, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 18'o004001, 16'hFFFF, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 18'o003776, 16'hC3A5, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 18'o003776, 16'h0000, 1'b0, 1'b0);

        // T6 reset during W1
        @(negedge CLOCK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 18'o000100;
        @(posedge CLOCK);
        #1;
        req_valid = 1'b0;
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b0;
        #1;
        ref_flag  = 1'b0;
        ref_paddr = '0;
        check("mid_rst_rsp_valid", 18'(rsp_valid), 18'd0);
        check("mid_rst_ready", 18'(req_ready), 18'd0);
        check("mid_rst_ena", 18'(mem_ena), 18'd0);
        check("mid_rst_addra", 18'(mem_addra), 18'd0);
        check("mid_rst_perr_addr", perr_addr, 18'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        check("rel_ready", 18'(req_ready), 18'd1);
        check("rel_ena", 18'(mem_ena), 18'd1);
        for (int i = 0; i < 6; i++) begin
            check("rel_no_rsp", 18'(rsp_valid), 18'd0);
            @(posedge CLOCK);
            #1;
        end

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [16:0] w;
            bit          wr, bt, bp, cl;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      w = 17'($urandom_range(NW, NW + 60));
            else if (sel < 6)  w = 17'($urandom_range(0, 15));
            else               w = 17'($urandom_range(0, NW - 1));
            wr = 1'($urandom);
            bt = 1'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            cl = !wr && ($urandom_range(0, 5) == 0);
            txn(wr, bt, {w, 1'($urandom)}, 16'($urandom), bp, cl);
            if ($urandom_range(0, 9) == 0) clr_alone();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
